user_nmi_arb2: RTL and testbench

Two-master, one-slave arbiter for the native memory interface (nmi: valid/ready/addr/wdata/wstrb/rdata). It lets two user-core instances, or a core plus a debug/DMA requester, share the single nmi port toward the SoC crossbar. Grants alternate round-robin and are held until the transaction completes. A watchdog terminates any transaction the slave never acknowledges, with an error response, so a hung slave cannot stall the core forever.

---
 rtl/user_nmi_arb_pkg.sv | 20 ++
 rtl/nmi_if.sv | 21 ++
 rtl/user_nmi_rr_pick.sv | 25 ++
 rtl/user_nmi_arb2.sv | 150 +++++++++++++++
 tb/tb_user_nmi_arb2.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_nmi_arb_pkg.sv
// rtl/user_nmi_arb_pkg.sv - shared types and constants for the two-master nmi arbiter
//
// Purpose: arbiter FSM state encoding, nmi field widths and the default
// error read data returned when the watchdog aborts a transaction.
// Ports: none (package).
package user_nmi_arb_pkg;

  localparam int unsigned NMI_AW = 32;
  localparam int unsigned NMI_DW = 32;
  localparam int unsigned NMI_SW = 4;

  localparam logic [NMI_DW-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

endpackage

// File: rtl/nmi_if.sv
// rtl/nmi_if.sv - native memory interface bundle (valid/ready/addr/wdata/wstrb/rdata)
//
// Purpose: one request/response channel of the native memory interface.
// Ports (modports):
//   master : drives valid, addr, wdata, wstrb; receives ready, rdata
//   slave  : receives valid, addr, wdata, wstrb; drives ready, rdata
interface nmi_if;
  import user_nmi_arb_pkg::*;

  logic              valid;
  logic              ready;
  logic [NMI_AW-1:0] addr;
  logic [NMI_DW-1:0] wdata;
  logic [NMI_SW-1:0] wstrb;
  logic [NMI_DW-1:0] rdata;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input  ready, input  rdata);
  modport slave  (input  valid, input  addr, input  wdata, input  wstrb,
                  output ready, output rdata);
endinterface

// File: rtl/user_nmi_rr_pick.sv
// rtl/user_nmi_rr_pick.sv - combinational two-way round-robin selector
//
// Purpose: choose one of two requesters; on a tie the one that was not
// served last wins.
// Ports:
//   i_req  [1:0] in  : request vector, bit n = requester n
//   i_last       in  : requester served last (0 = m0, 1 = m1)
//   o_gnt  [1:0] out : one-hot pick, 2'b00 when nothing is requested
module user_nmi_rr_pick (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/user_nmi_arb2.sv
// rtl/user_nmi_arb2.sv - two-master round-robin nmi arbiter with watchdog abort
//
// Purpose: lets two requesters share one nmi port. A grant is taken in IDLE,
// held through BUSY until the slave answers, and a watchdog turns a
// transaction the slave never acknowledges into an error response.
// Ports:
//   clk_i       in   : clock
//   rst_n_i     in   : asynchronous active-low reset
//   m0_nmi      slave  : requester 0
//   m1_nmi      slave  : requester 1
//   s_nmi       master : shared downstream port
//   grant_o     out [1:0]  : one-hot current owner, 2'b00 when idle
//   timeout_o   out        : one-cycle pulse while the abort response is given
//   err_addr_o  out [31:0] : address of the last aborted transaction (sticky)
module user_nmi_arb2
  import user_nmi_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [NMI_DW-1:0] ERR_RDATA      = DEFAULT_ERR_RDATA,
  parameter int unsigned       CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  nmi_if.slave              m0_nmi,
  nmi_if.slave              m1_nmi,
  nmi_if.master             s_nmi,
  output logic [1:0]        grant_o,
  output logic              timeout_o,
  output logic [NMI_AW-1:0] err_addr_o
);

  // A disabled watchdog still needs a legal one-bit counter.
  localparam int unsigned   CW       = (CNT_W < 1) ? 1 : CNT_W;
  localparam bit            WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [1:0]        r_grant;
  logic              r_last;
  logic [CW-1:0]     r_cnt;
  logic              r_timeout;
  logic [NMI_AW-1:0] r_err_addr;

  logic [1:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_sel_m1;
  logic              w_g_valid;
  logic [NMI_AW-1:0] w_g_addr;
  logic [NMI_DW-1:0] w_g_wdata;
  logic [NMI_SW-1:0] w_g_wstrb;
  logic              w_busy;
  logic              w_abort;
  logic              w_done;
  logic              w_wd_fire;
  logic              w_rsp_ready;
  logic [NMI_DW-1:0] w_rsp_rdata;

  assign w_req = {m1_nmi.valid, m0_nmi.valid};

  user_nmi_rr_pick u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_gnt  (w_pick)
  );

  // Request mux follows the registered grant.
  assign w_sel_m1  = r_grant[1];
  assign w_g_valid = w_sel_m1 ? m1_nmi.valid : m0_nmi.valid;
  assign w_g_addr  = w_sel_m1 ? m1_nmi.addr  : m0_nmi.addr;
  assign w_g_wdata = w_sel_m1 ? m1_nmi.wdata : m0_nmi.wdata;
  assign w_g_wstrb = w_sel_m1 ? m1_nmi.wstrb : m0_nmi.wstrb;

  assign w_busy  = (r_state == BUSY);
  assign w_abort = (r_state == ABORT);

  assign s_nmi.valid = w_busy & w_g_valid;
  assign s_nmi.addr  = w_g_addr;
  assign s_nmi.wdata = w_g_wdata;
  assign s_nmi.wstrb = w_g_wstrb;

  // A ready seen while the owner has withdrawn valid is not a completion.
  assign w_done    = w_busy & w_g_valid & s_nmi.ready;
  // Ready arriving on the limit cycle wins over the abort.
  assign w_wd_fire = WD_EN & w_busy & w_g_valid & ~s_nmi.ready & (r_cnt == CNT_LAST);

  // In ABORT the slave is ignored and the owner gets the error word instead.
  assign w_rsp_ready = w_done | w_abort;
  assign w_rsp_rdata = w_abort ? ERR_RDATA : s_nmi.rdata;

  assign m0_nmi.ready = r_grant[0] & w_rsp_ready;
  assign m1_nmi.ready = r_grant[1] & w_rsp_ready;
  assign m0_nmi.rdata = r_grant[0] ? w_rsp_rdata : '0;
  assign m1_nmi.rdata = r_grant[1] ? w_rsp_rdata : '0;

  assign grant_o    = r_grant;
  assign timeout_o  = r_timeout;
  assign err_addr_o = r_err_addr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_grant <= w_pick;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!w_g_valid) begin
            // Owner withdrew its request: drop it without touching fairness.
            r_grant <= 2'b00;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (s_nmi.ready) begin
            r_last  <= r_grant[1];
            r_grant <= 2'b00;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_wd_fire) begin
            r_timeout  <= 1'b1;
            r_err_addr <= w_g_addr;
            r_cnt      <= '0;
            r_state    <= ABORT;
          end else if (WD_EN) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ABORT: begin
          r_last  <= r_grant[1];
          r_grant <= 2'b00;
          r_state <= IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_nmi_arb2.sv
// tb/tb_user_nmi_arb2.sv - directed self-checking bench for user_nmi_arb2
module tb_user_nmi_arb2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  nmi_if ma0 ();
  nmi_if ma1 ();
  nmi_if sa ();
  nmi_if mb0 ();
  nmi_if mb1 ();
  nmi_if sb ();

  logic [1:0]  grant_a, grant_b;
  logic        to_a, to_b;
  logic [31:0] ea_a, ea_b;

  int total = 0;
  int bad   = 0;

  user_nmi_arb2 #(.TIMEOUT_CYCLES(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .m0_nmi(ma0), .m1_nmi(ma1), .s_nmi(sa),
    .grant_o(grant_a), .timeout_o(to_a), .err_addr_o(ea_a)
  );

  user_nmi_arb2 #(.TIMEOUT_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .m0_nmi(mb0), .m1_nmi(mb1), .s_nmi(sb),
    .grant_o(grant_b), .timeout_o(to_b), .err_addr_o(ea_b)
  );

  task automatic idle_all();
    ma0.valid = 0; ma0.addr = 0; ma0.wdata = 0; ma0.wstrb = 0;
    ma1.valid = 0; ma1.addr = 0; ma1.wdata = 0; ma1.wstrb = 0;
    mb0.valid = 0; mb0.addr = 0; mb0.wdata = 0; mb0.wstrb = 0;
    mb1.valid = 0; mb1.addr = 0; mb1.wdata = 0; mb1.wstrb = 0;
    sa.ready = 0; sa.rdata = 0;
    sb.ready = 0; sb.rdata = 0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    ma0.valid = 1; ma1.valid = 1; sa.ready = 1; sa.rdata = 32'h5555_5555;
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b exp 00", grant_a); end
    total++; if (grant_b !== 2'b00) begin bad++; $display("FAIL reset_grant_b: got %b exp 00", grant_b); end
    total++; if (sa.valid !== 1'b0) begin bad++; $display("FAIL reset_svalid: got %b exp 0", sa.valid); end
    total++; if ({ma0.ready, ma1.ready} !== 2'b00) begin bad++; $display("FAIL reset_mready: got %b exp 00", {ma0.ready, ma1.ready}); end
    total++; if (ma0.rdata !== 32'h0) begin bad++; $display("FAIL reset_m0_rdata: got %h exp 0", ma0.rdata); end
    total++; if (to_a !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b exp 0", to_a); end
    total++; if (ea_a !== 32'h0) begin bad++; $display("FAIL reset_err_addr: got %h exp 0", ea_a); end
    idle_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h1000_0000;
    #1;
    total++; if (grant_a !== 2'b00 || sa.valid !== 1'b0) begin bad++; $display("FAIL rd_idle: got grant=%b sv=%b exp 00/0", grant_a, sa.valid); end
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL rd_grant: got %b exp 01", grant_a); end
    total++; if (sa.valid !== 1'b1 || sa.addr !== 32'h1000_0000) begin bad++; $display("FAIL rd_fwd: got v=%b a=%h exp 1/10000000", sa.valid, sa.addr); end
    @(negedge clk); #1;
    total++; if (ma0.ready !== 1'b0) begin bad++; $display("FAIL rd_wait: got %b exp 0", ma0.ready); end
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h1234_5678;
    #1;
    total++; if (ma0.ready !== 1'b1 || ma0.rdata !== 32'h1234_5678) begin bad++; $display("FAIL rd_resp: got r=%b d=%h exp 1/12345678", ma0.ready, ma0.rdata); end
    total++; if (ma1.ready !== 1'b0) begin bad++; $display("FAIL rd_m1_quiet: got %b exp 0", ma1.ready); end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0;
    #1;
    total++; if (grant_a !== 2'b00 || ma0.ready !== 1'b0) begin bad++; $display("FAIL rd_back_idle: got grant=%b r=%b exp 00/0", grant_a, ma0.ready); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4];
    int r0, r1;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    r0 = 0; r1 = 0;
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h2000_0000;
    ma1.valid = 1; ma1.addr = 32'h2000_1000;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      sa.ready = 0;
      #1;
      total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL rr_idle[%0d]: got %b exp 00", k, grant_a); end
      @(negedge clk); #1;
      total++; if (grant_a !== exp_g[k]) begin bad++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, grant_a, exp_g[k]); end
      @(negedge clk);
      sa.ready = 1; sa.rdata = 32'h100 + k;
      #1;
      total++; if ({ma1.ready, ma0.ready} !== exp_g[k]) begin bad++; $display("FAIL rr_ready[%0d]: got %b exp %b", k, {ma1.ready, ma0.ready}, exp_g[k]); end
      r0 += int'(ma0.ready);
      r1 += int'(ma1.ready);
    end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0; ma1.valid = 0;
    total++; if (r0 != 2 || r1 != 2) begin bad++; $display("FAIL rr_counts: got m0=%0d m1=%0d exp 2/2", r0, r1); end
  endtask

  task automatic test_write();
    do_reset();
    ma0.addr = 32'hFFFF_FFFF; ma0.wdata = 32'h0F0F_0F0F; ma0.wstrb = 4'hF;
    ma1.valid = 1; ma1.addr = 32'h0300_0010; ma1.wdata = 32'hA5A5_A5A5; ma1.wstrb = 4'b0011;
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b10 || sa.valid !== 1'b1) begin bad++; $display("FAIL wr_grant: got grant=%b sv=%b exp 10/1", grant_a, sa.valid); end
    total++; if (sa.addr !== 32'h0300_0010) begin bad++; $display("FAIL wr_addr: got %h exp 03000010", sa.addr); end
    total++; if (sa.wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wr_wdata: got %h exp a5a5a5a5", sa.wdata); end
    total++; if (sa.wstrb !== 4'b0011) begin bad++; $display("FAIL wr_wstrb: got %b exp 0011", sa.wstrb); end
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h7777_7777;
    #1;
    total++; if (ma1.ready !== 1'b1 || ma1.rdata !== 32'h7777_7777) begin bad++; $display("FAIL wr_resp: got r=%b d=%h exp 1/77777777", ma1.ready, ma1.rdata); end
    total++; if (ma0.ready !== 1'b0 || ma0.rdata !== 32'h0) begin bad++; $display("FAIL wr_m0_quiet: got r=%b d=%h exp 0/0", ma0.ready, ma0.rdata); end
    @(negedge clk);
    sa.ready = 0; ma1.valid = 0;
  endtask

  task automatic test_timeout();
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h0400_0000;
    ma1.valid = 1; ma1.addr = 32'h0500_0004;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      total++;
      if ({grant_a, sa.valid, to_a, ma0.ready} !== 5'b01_1_0_0) begin
        bad++; $display("FAIL to_busy[%0d]: got g=%b sv=%b to=%b r=%b exp 01/1/0/0", i, grant_a, sa.valid, to_a, ma0.ready);
      end
    end
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h1111_1111;
    #1;
    total++; if (sa.valid !== 1'b0) begin bad++; $display("FAIL to_svalid: got %b exp 0", sa.valid); end
    total++; if (ma0.ready !== 1'b1 || ma0.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL to_resp: got r=%b d=%h exp 1/deadbeef", ma0.ready, ma0.rdata); end
    total++; if (to_a !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b exp 1", to_a); end
    total++; if (ea_a !== 32'h0400_0000) begin bad++; $display("FAIL to_err_addr: got %h exp 04000000", ea_a); end
    total++; if (ma1.ready !== 1'b0) begin bad++; $display("FAIL to_m1_quiet: got %b exp 0", ma1.ready); end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0;
    #1;
    total++; if (grant_a !== 2'b00 || to_a !== 1'b0 || sa.valid !== 1'b0) begin bad++; $display("FAIL to_after: got g=%b to=%b sv=%b exp 00/0/0", grant_a, to_a, sa.valid); end
    total++; if (ea_a !== 32'h0400_0000) begin bad++; $display("FAIL to_sticky: got %h exp 04000000", ea_a); end
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b10 || sa.addr !== 32'h0500_0004 || sa.valid !== 1'b1) begin bad++; $display("FAIL to_next_m1: got g=%b a=%h sv=%b exp 10/05000004/1", grant_a, sa.addr, sa.valid); end
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h0;
    #1;
    total++; if (ma1.ready !== 1'b1) begin bad++; $display("FAIL to_m1_done: got %b exp 1", ma1.ready); end
    @(negedge clk);
    sa.ready = 0; ma1.valid = 0;
  endtask

  task automatic test_limit_ready();
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h0600_0000;
    for (int i = 1; i <= 7; i++) @(negedge clk);
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h2468_ACE0;
    #1;
    total++; if (ma0.ready !== 1'b1 || ma0.rdata !== 32'h2468_ACE0) begin bad++; $display("FAIL lim_resp: got r=%b d=%h exp 1/2468ace0", ma0.ready, ma0.rdata); end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0;
    #1;
    total++; if (grant_a !== 2'b00 || to_a !== 1'b0 || ea_a !== 32'h0) begin bad++; $display("FAIL lim_no_abort: got g=%b to=%b ea=%h exp 00/0/0", grant_a, to_a, ea_a); end
  endtask

  task automatic test_valid_drop();
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h0800_0000;
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL drop_grant: got %b exp 01", grant_a); end
    @(negedge clk);
    ma0.valid = 0; sa.ready = 1; sa.rdata = 32'h3333_3333;
    #1;
    total++; if (sa.valid !== 1'b0 || ma0.ready !== 1'b0) begin bad++; $display("FAIL drop_follow: got sv=%b r=%b exp 0/0", sa.valid, ma0.ready); end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 1; ma1.valid = 1;
    #1;
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL drop_idle: got %b exp 00", grant_a); end
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL drop_last_kept: got %b exp 01", grant_a); end
    @(negedge clk);
    sa.ready = 1;
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0; ma1.valid = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    ma0.valid = 1; ma0.addr = 32'h0900_0000;
    @(negedge clk);
    @(negedge clk);
    sa.ready = 1;
    @(negedge clk);
    sa.ready = 0; ma1.valid = 1; ma1.addr = 32'h0900_0100;
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b10) begin bad++; $display("FAIL ar_pre_grant: got %b exp 10", grant_a); end
    rst_n = 1'b0; sa.ready = 1;
    #1;
    total++; if (grant_a !== 2'b00 || sa.valid !== 1'b0) begin bad++; $display("FAIL ar_async: got g=%b sv=%b exp 00/0", grant_a, sa.valid); end
    total++; if ({ma0.ready, ma1.ready} !== 2'b00) begin bad++; $display("FAIL ar_mready: got %b exp 00", {ma0.ready, ma1.ready}); end
    @(negedge clk);
    sa.ready = 0; rst_n = 1'b1;
    #1;
    total++; if (grant_a !== 2'b00) begin bad++; $display("FAIL ar_idle: got %b exp 00", grant_a); end
    @(negedge clk); #1;
    total++; if (grant_a !== 2'b01) begin bad++; $display("FAIL ar_m0_first: got %b exp 01", grant_a); end
    @(negedge clk);
    sa.ready = 1; sa.rdata = 32'h4444_4444;
    #1;
    total++; if (ma0.ready !== 1'b1 || ma0.rdata !== 32'h4444_4444) begin bad++; $display("FAIL ar_resp: got r=%b d=%h exp 1/44444444", ma0.ready, ma0.rdata); end
    @(negedge clk);
    sa.ready = 0; ma0.valid = 0; ma1.valid = 0;
  endtask

  task automatic test_no_watchdog();
    int odd;
    odd = 0;
    do_reset();
    mb0.valid = 1; mb0.addr = 32'h0700_0000;
    for (int i = 1; i <= 5000; i++) begin
      @(negedge clk); #1;
      if (to_b !== 1'b0 || mb0.ready !== 1'b0 || sb.valid !== 1'b1) odd++;
    end
    total++; if (odd != 0) begin bad++; $display("FAIL nowd_stall: got %0d bad cycles exp 0", odd); end
    @(negedge clk);
    sb.ready = 1; sb.rdata = 32'hCAFE_F00D;
    #1;
    total++; if (mb0.ready !== 1'b1 || mb0.rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL nowd_resp: got r=%b d=%h exp 1/cafef00d", mb0.ready, mb0.rdata); end
    total++; if (grant_b !== 2'b01 || to_b !== 1'b0 || ea_b !== 32'h0) begin bad++; $display("FAIL nowd_flags: got g=%b to=%b ea=%h exp 01/0/0", grant_b, to_b, ea_b); end
    @(negedge clk);
    sb.ready = 0; mb0.valid = 0;
    #1;
    total++; if (grant_b !== 2'b00) begin bad++; $display("FAIL nowd_idle: got %b exp 00", grant_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_timeout();
    test_limit_ready();
    test_valid_drop();
    test_async_reset();
    test_no_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
